// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop walk the
// operands LSB first, one bit per clock, under a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one operand bit processed per edge, LSB first
// DONE  | one-cycle done pulse; a new start is accepted here as in IDLE
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sum_bit;
    logic             carry_nx;
    logic [WIDTH-1:0] r_next;

    // Full-adder cell on the current LSBs; the sum bit enters the result at the MSB
    always_comb begin
        sum_bit  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_nx = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        r_next   = (r_sh_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
    end

    // Next-state and datapath: subtraction is a + ~b + ~cin, so cout reads as not-borrow
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    r_sh_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = r_next;
                carry_d = carry_nx;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    s_d     = r_next;
                    cout_d  = carry_nx;
                    ovf_d   = carry_q ^ carry_nx;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and output registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance driven from a vector table
// plus handshake/reset sequences, and a 1-bit instance checked exhaustively.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] s8;

    logic       start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] s1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .cin(cin1), .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       sb;
        logic [7:0] av;
        logic [7:0] bv;
        logic       ci;
        logic [7:0] es;
        logic       ec;
        logic       eo;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one 8-bit operation and wait for its done; reports latency,
    // whether busy dropped early, and whether outputs moved before done.
    task automatic run8(input logic sb, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input bit poke,
                        output int lat, output bit gap, output bit unstable);
        logic [7:0] s_prev;
        logic       c_prev, o_prev;
        @(negedge clk);
        sub8 = sb; a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = ~av; b8 = ~bv; cin8 = ~ci; sub8 = ~sb;
        s_prev = s8; c_prev = cout8; o_prev = ovf8;
        lat = 0; gap = 0; unstable = 0;
        while (!done8 && lat < 30) begin
            if (!busy8) gap = 1;
            if (s8 !== s_prev || cout8 !== c_prev || ovf8 !== o_prev) unstable = 1;
            if (poke && lat == 3) begin
                start8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A; sub8 = 1'b0; cin8 = 1'b1;
            end
            if (poke && lat == 5) start8 = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run1(input logic sb, input logic av, input logic bv, input logic ci,
                        output int lat);
        @(negedge clk);
        sub1 = sb; a1 = av; b1 = bv; cin1 = ci; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        a1 = ~av; b1 = ~bv; cin1 = ~ci; sub1 = ~sb;
        lat = 0;
        while (!done1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int  lat;
        bit  gap, unstable, saw_done;
        int  done_cyc1, done_cyc2;

        vecs[0] = '{1'b0, 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 8'h05, 8'h03, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        // Reset held with start asserted
        rst_n = 1'b0; start8 = 1'b1; start1 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_s", s8, 8'h00);
        chk("rst_cout", cout8, 0);
        chk("rst_ovf", ovf8, 0);
        @(negedge clk);
        rst_n = 1'b1; start8 = 1'b0; start1 = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy8, 0);
        chk("idle_done", done8, 0);
        chk("idle_s", s8, 8'h00);
        chk("idle_cout_ovf", {cout8, ovf8}, 2'b00);

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            run8(vecs[i].sb, vecs[i].av, vecs[i].bv, vecs[i].ci, 1'b0, lat, gap, unstable);
            chk($sformatf("v%0d_latency", i), lat, 8);
            chk($sformatf("v%0d_busy_gap", i), gap, 0);
            chk($sformatf("v%0d_early_output", i), unstable, 0);
            chk($sformatf("v%0d_busy_at_done", i), busy8, 0);
            chk($sformatf("v%0d_s", i), s8, vecs[i].es);
            chk($sformatf("v%0d_cout", i), cout8, vecs[i].ec);
            chk($sformatf("v%0d_ovf", i), ovf8, vecs[i].eo);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), done8, 0);
            chk($sformatf("v%0d_s_hold", i), s8, vecs[i].es);
        end

        // start re-asserted during RUN is ignored
        run8(1'b0, 8'h12, 8'h34, 1'b0, 1'b1, lat, gap, unstable);
        chk("poke_latency", lat, 8);
        chk("poke_s", s8, 8'h46);
        chk("poke_cout_ovf", {cout8, ovf8}, 2'b00);
        @(posedge clk); #1;
        chk("poke_no_restart", busy8, 0);

        // Back-to-back: start held in the DONE cycle
        run8(1'b0, 8'h01, 8'h02, 1'b0, 1'b0, lat, gap, unstable);
        done_cyc1 = cyc;
        chk("b2b_first_s", s8, 8'h03);
        run8(1'b1, 8'h09, 8'h04, 1'b0, 1'b0, lat, gap, unstable);
        done_cyc2 = cyc;
        chk("b2b_spacing", done_cyc2 - done_cyc1, 9);
        chk("b2b_second_s", s8, 8'h05);
        chk("b2b_second_cout", cout8, 1);

        // Asynchronous reset during bit 4
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h5A; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_s", s8, 8'h00);
        #1 rst_n = 1'b1;
        saw_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 || busy8) saw_done = 1;
        end
        chk("mid_rst_no_done", saw_done, 0);
        chk("mid_rst_s_after", s8, 8'h00);
        run8(1'b0, 8'h01, 8'h01, 1'b0, 1'b0, lat, gap, unstable);
        chk("post_rst_latency", lat, 8);
        chk("post_rst_s", s8, 8'h02);

        // WIDTH = 1, exhaustive
        for (int i = 0; i < 16; i++) begin
            logic sb, av, bv, ci, es, ec, eo;
            int tot;
            sb = i[3]; av = i[2]; bv = i[1]; ci = i[0];
            if (!sb) begin
                tot = int'(av) + int'(bv) + int'(ci);
                es  = tot[0];
                ec  = tot[1];
                eo  = ci ^ ec;
            end else begin
                tot = int'(av) - int'(bv) - int'(ci);
                es  = tot[0];
                ec  = (int'(av) >= int'(bv) + int'(ci));
                eo  = ~ci ^ ec;
            end
            run1(sb, av, bv, ci, lat);
            chk($sformatf("w1_%0d_latency", i), lat, 1);
            chk($sformatf("w1_%0d_s", i), s1, es);
            chk($sformatf("w1_%0d_cout", i), cout1, ec);
            chk($sformatf("w1_%0d_ovf", i), ovf1, eo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
